// File: rtl/mastermind_pkg.sv
// Shared Mastermind definitions: peg geometry, counter widths and the
// scoring FSM state encoding, reused by the history and feedback paths.
package mastermind_pkg;

    localparam int MM_NUM_PEGS = 4;
    localparam int MM_COLOR_W  = 3;
    localparam int MM_CNT_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXACT   = 2'd1,
        ST_PARTIAL = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/peg_scorer.sv
// Mastermind peg scorer: latches a code/guess pair, counts exact matches in
// 4 cycles and colour-only matches in a fixed 16-cycle pairwise scan, then
// publishes exact/partial/win with a one-cycle done pulse.
module peg_scorer
    import mastermind_pkg::*;
#(
    parameter int NUM_PEGS = MM_NUM_PEGS,
    parameter int COLOR_W  = MM_COLOR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COLOR_W-1:0] code0,
    input  logic [COLOR_W-1:0] code1,
    input  logic [COLOR_W-1:0] code2,
    input  logic [COLOR_W-1:0] code3,
    input  logic [COLOR_W-1:0] guess0,
    input  logic [COLOR_W-1:0] guess1,
    input  logic [COLOR_W-1:0] guess2,
    input  logic [COLOR_W-1:0] guess3,
    output logic               busy,
    output logic               done,
    output logic [MM_CNT_W-1:0] exact,
    output logic [MM_CNT_W-1:0] partial,
    output logic               win
);

    state_e state_q, state_d;

    // Low two bits index the peg in EXACT; in PARTIAL [3:2]=guess i, [1:0]=code j.
    logic [3:0]          cnt_q, cnt_d;
    logic [COLOR_W-1:0]  code_q  [NUM_PEGS];
    logic [COLOR_W-1:0]  code_d  [NUM_PEGS];
    logic [COLOR_W-1:0]  guess_q [NUM_PEGS];
    logic [COLOR_W-1:0]  guess_d [NUM_PEGS];
    logic [NUM_PEGS-1:0] gused_q, gused_d;
    logic [NUM_PEGS-1:0] cused_q, cused_d;
    logic [MM_CNT_W-1:0] ex_acc_q, ex_acc_d;
    logic [MM_CNT_W-1:0] pa_acc_q, pa_acc_d;
    logic [MM_CNT_W-1:0] exact_q, exact_d;
    logic [MM_CNT_W-1:0] partial_q, partial_d;
    logic                win_q, win_d;

    logic [1:0] pi;
    logic [1:0] pj;

    // Next-state, operand capture, match accumulation and result publication.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        guess_d   = guess_q;
        gused_d   = gused_q;
        cused_d   = cused_q;
        ex_acc_d  = ex_acc_q;
        pa_acc_d  = pa_acc_q;
        exact_d   = exact_q;
        partial_d = partial_q;
        win_d     = win_q;
        pi        = cnt_q[3:2];
        pj        = cnt_q[1:0];

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    code_d[0]  = code0;
                    code_d[1]  = code1;
                    code_d[2]  = code2;
                    code_d[3]  = code3;
                    guess_d[0] = guess0;
                    guess_d[1] = guess1;
                    guess_d[2] = guess2;
                    guess_d[3] = guess3;
                    gused_d    = '0;
                    cused_d    = '0;
                    ex_acc_d   = '0;
                    pa_acc_d   = '0;
                    cnt_d      = '0;
                    state_d    = ST_EXACT;
                end
            end
            ST_EXACT: begin
                if (guess_q[pj] == code_q[pj]) begin
                    ex_acc_d     = ex_acc_q + 3'd1;
                    gused_d[pj]  = 1'b1;
                    cused_d[pj]  = 1'b1;
                end
                if (pj == 2'd3) begin
                    cnt_d   = '0;
                    state_d = ST_PARTIAL;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_PARTIAL: begin
                if ((guess_q[pi] == code_q[pj]) && !gused_q[pi] && !cused_q[pj]) begin
                    pa_acc_d    = pa_acc_q + 3'd1;
                    gused_d[pi] = 1'b1;
                    cused_d[pj] = 1'b1;
                end
                if (cnt_q == 4'd15) begin
                    // Publish on the entry edge so the final pair's match is
                    // visible in the DONE cycle itself.
                    cnt_d     = '0;
                    exact_d   = ex_acc_q;
                    partial_d = pa_acc_d;
                    win_d     = (ex_acc_q == 3'(NUM_PEGS));
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            gused_q   <= '0;
            cused_q   <= '0;
            ex_acc_q  <= '0;
            pa_acc_q  <= '0;
            exact_q   <= '0;
            partial_q <= '0;
            win_q     <= 1'b0;
            for (int unsigned k = 0; k < NUM_PEGS; k++) begin
                code_q[k]  <= '0;
                guess_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gused_q   <= gused_d;
            cused_q   <= cused_d;
            ex_acc_q  <= ex_acc_d;
            pa_acc_q  <= pa_acc_d;
            exact_q   <= exact_d;
            partial_q <= partial_d;
            win_q     <= win_d;
            code_q    <= code_d;
            guess_q   <= guess_d;
        end
    end

    // Status decodes straight from state so reset clears them immediately.
    always_comb begin
        busy    = (state_q == ST_EXACT) || (state_q == ST_PARTIAL);
        done    = (state_q == ST_DONE);
        exact   = exact_q;
        partial = partial_q;
        win     = win_q;
    end

endmodule

// File: tb/tb_peg_scorer.sv
// Self-checking bench for peg_scorer: directed Mastermind cases, randomized
// scoring against a colour-count reference model, start/operand immunity,
// mid-scoring reset and back-to-back throughput.
module tb_peg_scorer;

    typedef logic [3:0][2:0] pegs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    pegs_t      code_v;
    pegs_t      guess_v;
    logic       busy;
    logic       done;
    logic [2:0] exact;
    logic [2:0] partial;
    logic       win;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    peg_scorer #(.NUM_PEGS(4), .COLOR_W(3)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .code0  (code_v[0]),
        .code1  (code_v[1]),
        .code2  (code_v[2]),
        .code3  (code_v[3]),
        .guess0 (guess_v[0]),
        .guess1 (guess_v[1]),
        .guess2 (guess_v[2]),
        .guess3 (guess_v[3]),
        .busy   (busy),
        .done   (done),
        .exact  (exact),
        .partial(partial),
        .win    (win)
    );

    // Standard Mastermind rule: total colour overlap minus positional hits.
    function automatic void model(input pegs_t c, input pegs_t g,
                                  output int ex, output int pa);
        int cc[8];
        int gc[8];
        int tot;
        ex = 0;
        tot = 0;
        for (int k = 0; k < 8; k++) begin cc[k] = 0; gc[k] = 0; end
        for (int k = 0; k < 4; k++) begin
            if (c[k] == g[k]) ex++;
            cc[c[k]]++;
            gc[g[k]]++;
        end
        for (int k = 0; k < 8; k++) tot += (cc[k] < gc[k]) ? cc[k] : gc[k];
        pa = tot - ex;
    endfunction

    function automatic pegs_t mk(input int a, input int b, input int c, input int d);
        pegs_t p;
        p[0] = 3'(a); p[1] = 3'(b); p[2] = 3'(c); p[3] = 3'(d);
        return p;
    endfunction

    // Drives one scoring request and reports latency (edges after the
    // start-sampling edge, -1 on timeout), the results and whether busy
    // stayed high on every edge before done.
    task automatic score(input pegs_t c, input pegs_t g, output int lat,
                         output logic [2:0] ex, output logic [2:0] pa,
                         output logic w, output logic busy_ok);
        int guard = 0;
        @(negedge clk);
        while ((done || busy) && guard < 50) begin @(negedge clk); guard++; end
        code_v  = c;
        guess_v = g;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        busy_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin lat = k; break; end
            if (!busy) busy_ok = 1'b0;
        end
        ex = exact;
        pa = partial;
        w  = win;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        start   = 1'b1;
        code_v  = mk(1, 2, 3, 4);
        guess_v = mk(1, 2, 3, 4);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, exact, partial, win} !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b done=%b exact=%0d partial=%0d win=%b, required all 0",
                     busy, done, exact, partial, win);
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        pegs_t cs[4];
        pegs_t gs[4];
        int    eex[4];
        int    epa[4];
        int lat;
        logic [2:0] ex, pa;
        logic w, bok;
        cs[0] = mk(1, 2, 3, 4); gs[0] = mk(1, 2, 3, 4); eex[0] = 4; epa[0] = 0;
        cs[1] = mk(1, 2, 3, 4); gs[1] = mk(4, 3, 2, 1); eex[1] = 0; epa[1] = 4;
        cs[2] = mk(1, 1, 2, 2); gs[2] = mk(1, 2, 1, 1); eex[2] = 1; epa[2] = 2;
        cs[3] = mk(5, 5, 5, 5); gs[3] = mk(5, 0, 0, 0); eex[3] = 1; epa[3] = 0;
        for (int t = 0; t < 4; t++) begin
            score(cs[t], gs[t], lat, ex, pa, w, bok);
            checks++;
            if (lat !== 20) begin
                failures++;
                $display("FAIL directed%0d_latency: got %0d edges, required 20", t, lat);
            end
            checks++;
            if (bok !== 1'b1) begin
                failures++;
                $display("FAIL directed%0d_busy: busy dropped before done, required high throughout", t);
            end
            checks++;
            if (ex !== 3'(eex[t]) || pa !== 3'(epa[t]) || w !== (eex[t] == 4)) begin
                failures++;
                $display("FAIL directed%0d_result: exact=%0d partial=%0d win=%b, required %0d %0d %b",
                         t, ex, pa, w, eex[t], epa[t], eex[t] == 4);
            end
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL directed%0d_pulse: done=%b busy=%b after DONE, required 0 0", t, done, busy);
            end
        end
    endtask

    task automatic test_random();
        pegs_t c, g;
        int eex, epa, lat;
        logic [2:0] ex, pa;
        logic w, bok;
        for (int t = 0; t < 30; t++) begin
            int hi = (t % 2 == 0) ? 2 : 7;
            for (int k = 0; k < 4; k++) begin
                c[k] = 3'($urandom_range(0, hi));
                g[k] = 3'($urandom_range(0, hi));
            end
            if (t % 7 == 3) g = c;
            model(c, g, eex, epa);
            score(c, g, lat, ex, pa, w, bok);
            checks++;
            if (lat !== 20 || ex !== 3'(eex) || pa !== 3'(epa) || w !== (eex == 4)) begin
                failures++;
                $display("FAIL random%0d: code=%h guess=%h lat=%0d exact=%0d partial=%0d win=%b, required lat=20 %0d %0d %b",
                         t, c, g, lat, ex, pa, w, eex, epa, eex == 4);
            end
        end
    endtask

    task automatic test_start_ignored();
        pegs_t c, g;
        int eex, epa;
        int ndone = 0;
        int first = -1;
        int guard = 0;
        c = mk(1, 1, 2, 2);
        g = mk(1, 2, 1, 1);
        model(c, g, eex, epa);
        @(negedge clk);
        while ((done || busy) && guard < 50) begin @(negedge clk); guard++; end
        code_v  = c;
        guess_v = g;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (k == 3 || k == 9) begin
                start   = 1'b1;
                guess_v = mk(k, 7, 6, 5);
                code_v  = mk(6, k, 4, 3);
            end
            if (k == 4 || k == 10) start = 1'b0;
            if (done) begin
                ndone++;
                if (first < 0) begin
                    first = k;
                    checks++;
                    if (exact !== 3'(eex) || partial !== 3'(epa) || win !== 1'b0) begin
                        failures++;
                        $display("FAIL ignore_result: exact=%0d partial=%0d win=%b, required %0d %0d 0",
                                 exact, partial, win, eex, epa);
                    end
                end
            end
        end
        checks++;
        if (ndone !== 1 || first !== 20) begin
            failures++;
            $display("FAIL ignore_pulses: %0d done pulses first at %0d, required 1 at 20", ndone, first);
        end
    endtask

    task automatic test_reset_midscore();
        int lat;
        logic [2:0] ex, pa;
        logic w, bok;
        int guard = 0;
        @(negedge clk);
        while ((done || busy) && guard < 50) begin @(negedge clk); guard++; end
        code_v  = mk(3, 3, 3, 3);
        guess_v = mk(3, 3, 3, 3);
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        start = 1'b1;
        #1;
        checks++;
        if ({busy, done, exact, partial, win} !== 9'b0) begin
            failures++;
            $display("FAIL midreset_outputs: busy=%b done=%b exact=%0d partial=%0d win=%b, required all 0",
                     busy, done, exact, partial, win);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_start_ignored: busy=%b with start during reset, required 0", busy);
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        score(mk(7, 0, 7, 0), mk(0, 7, 0, 7), lat, ex, pa, w, bok);
        checks++;
        if (lat !== 20 || ex !== 3'd0 || pa !== 3'd4 || w !== 1'b0) begin
            failures++;
            $display("FAIL midreset_rescore: lat=%0d exact=%0d partial=%0d win=%b, required 20 0 4 0",
                     lat, ex, pa, w);
        end
    endtask

    task automatic test_back_to_back();
        pegs_t cs[3];
        pegs_t gs[3];
        int eex[3];
        int epa[3];
        int at[3];
        int nd = 0;
        int guard = 0;
        logic [2:0] hold_ex, hold_pa;
        logic stable_ok = 1'b1;
        cs[0] = mk(1, 2, 3, 4); gs[0] = mk(1, 2, 3, 4);
        cs[1] = mk(6, 6, 1, 0); gs[1] = mk(0, 6, 6, 2);
        for (int k = 0; k < 4; k++) begin
            cs[2][k] = 3'($urandom_range(0, 7));
            gs[2][k] = 3'($urandom_range(0, 7));
        end
        for (int t = 0; t < 3; t++) model(cs[t], gs[t], eex[t], epa[t]);
        @(negedge clk);
        while ((done || busy) && guard < 50) begin @(negedge clk); guard++; end
        code_v  = cs[0];
        guess_v = gs[0];
        start   = 1'b1;
        @(posedge clk);
        hold_ex = 3'd0;
        hold_pa = 3'd0;
        for (int k = 1; k <= 70; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (nd < 3) begin
                    at[nd] = k;
                    checks++;
                    if (exact !== 3'(eex[nd]) || partial !== 3'(epa[nd]) || win !== (eex[nd] == 4)) begin
                        failures++;
                        $display("FAIL b2b%0d_result: exact=%0d partial=%0d win=%b, required %0d %0d %b",
                                 nd, exact, partial, win, eex[nd], epa[nd], eex[nd] == 4);
                    end
                    hold_ex = exact;
                    hold_pa = partial;
                    if (nd < 2) begin
                        code_v  = cs[nd + 1];
                        guess_v = gs[nd + 1];
                    end
                end
                nd++;
            end else if (nd > 0 && (exact !== hold_ex || partial !== hold_pa)) begin
                stable_ok = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (nd !== 3 || at[0] !== 20 || at[1] !== 42 || at[2] !== 64) begin
            failures++;
            $display("FAIL b2b_timing: %0d pulses at %0d,%0d,%0d, required 3 at 20,42,64",
                     nd, at[0], at[1], at[2]);
        end
        checks++;
        if (stable_ok !== 1'b1) begin
            failures++;
            $display("FAIL b2b_hold: results changed between done pulses, required stable");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_reset_midscore();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/peg_scorer.md
PEG_SCORER -- requirements
Module: peg_scorer

Interface
REQ-001 SHALL have parameter NUM_PEGS, default 4, number of pegs per code/guess (fixed at 4 in this revision).
REQ-002 SHALL have parameter COLOR_W, default 3, bits per peg colour (8 colours).
REQ-003 SHALL have port clk  input  1  system clock; one clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to score the presented operands; sampled only in IDLE.
REQ-006 SHALL have ports code0..code3  input  3 each  secret code pegs, position 0..3.
REQ-007 SHALL have ports guess0..guess3  input  3 each  submitted guess pegs, position 0..3.
REQ-008 SHALL have port busy  output  1  high while scoring is in progress (EXACT or PARTIAL state).
REQ-009 SHALL have port done  output  1  single-cycle pulse; results are valid.
REQ-010 SHALL have port exact  output  3  count of pegs matching colour and position (0..4).
REQ-011 SHALL have port partial  output  3  count of pegs matching colour only (0..4).
REQ-012 SHALL have port win  output  1  high when exact == 4; updated with done.

Function
REQ-013 SHALL implement FSM states IDLE, EXACT, PARTIAL, DONE; DONE returns to IDLE unconditionally after one cycle.
REQ-014 SHALL, in IDLE with start=1 at a rising edge, latch all eight operands into internal registers, clear the exact-used/code-used flags and counters, and enter EXACT.
REQ-015 SHALL ignore start in EXACT, PARTIAL and DONE; latched operands are immune to input changes after capture.
REQ-016 SHALL spend exactly 4 cycles in EXACT, one position per cycle (index 0..3): equal colours increment the exact accumulator and set both the guess-used and code-used flags for that index.
REQ-017 SHALL spend exactly 16 cycles in PARTIAL, scanning guess index i 0..3 (outer) against code index j 0..3 (inner).
REQ-018 SHALL count a partial match for pair (i,j) only if guess[i]==code[j], guess i unused and code j unused; both flags are then set, so the lowest free j claims guess i and each peg counts at most once.
REQ-019 SHALL keep PARTIAL latency fixed at 16 cycles regardless of early matches (no skipping).
REQ-020 SHALL enter DONE after the 20th rising edge following the start-sampling edge; in DONE, done=1 and exact, partial and win are updated from the accumulators.
REQ-021 SHALL hold exact, partial and win stable from DONE until the next DONE; accumulators are internal, so outputs never show partial sums.
REQ-022 SHALL drive busy=1 in EXACT and PARTIAL only; busy=0 in IDLE and DONE.
REQ-023 SHALL keep accumulators 3 bits wide; exact+partial never exceeds 4 by construction, and no wrap is possible.
REQ-024 SHALL accept start in the cycle immediately after DONE, with no dead cycle beyond IDLE.

Reset
REQ-025 SHALL, on reset=1 at any time including mid-scoring, asynchronously force state IDLE, busy=0, done=0, exact=0, partial=0, win=0, and clear all flags, counters and latched operands.
REQ-026 SHALL ignore start while reset is high; the first start after deassertion SHALL score normally.

Structure
REQ-027 SHALL take NUM_PEGS, COLOR_W and FSM state encodings from shared package mastermind_pkg, reused by the history and feedback paths.
REQ-028 SHALL be a single module with no sub-modules; the per-pair comparator is an inline equality with no separate block.

Verification
REQ-029 SHALL cover: code 1,2,3,4 with guess 1,2,3,4 -> done 20 edges after start, exact=4, partial=0, win=1.
REQ-030 SHALL cover: code 1,2,3,4 with guess 4,3,2,1 -> exact=0, partial=4, win=0.
REQ-031 SHALL cover duplicates: code 1,1,2,2 with guess 1,2,1,1 -> exact=1, partial=2; and code 5,5,5,5 with guess 5,0,0,0 -> exact=1, partial=0.
REQ-032 SHALL cover: start re-pulsed and guess inputs changed during busy -> no restart, result from originally latched operands, exactly one done pulse.
REQ-033 SHALL cover: reset asserted 10 cycles into scoring -> all outputs 0 and busy 0 immediately; new start with code 7,0,7,0 and guess 0,7,0,7 -> exact=0, partial=4.
REQ-034 SHALL cover back-to-back: start held high continuously -> a new scoring begins the cycle after each DONE, one done pulse every 22 cycles.
